// File: rtl/aes_pkg.sv
// AES-128 constants and lookups shared by the key schedule and the round datapath.
package aes_pkg;

    localparam logic [1:0] SEL_FIRST = 2'b00;
    localparam logic [1:0] SEL_MID   = 2'b01;
    localparam logic [1:0] SEL_LAST  = 2'b10;
    localparam logic [3:0] NR        = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Byte 0 of the table sits in the top bits, so entry b starts at bit 8*(255-b).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: derives round key r+1 from round key r.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_w3[8*gi +: 8] = aes_sbox(rot_w3[8*gi +: 8]);
        end
    endgenerate

    assign n0 = w0 ^ sub_w3 ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption control: one round per clock through an external
// combinational round datapath, with the key schedule computed on the fly.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] kin,
    input  logic         krdy,
    input  logic [127:0] din,
    input  logic         drdy,
    output logic [127:0] dout,
    output logic         dvld,
    output logic         busy,
    output logic         kvld,
    output logic [127:0] core_din,
    output logic [127:0] core_kin,
    output logic [1:0]   core_sel,
    input  logic [127:0] core_dout
);

    seq_state_e   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         kvld_q, kvld_d;
    logic [127:0] dout_q, dout_d;
    logic         dvld_q, dvld_d;
    logic [127:0] rk_next;

    aes_key_expand_step u_key_step (
        .rk      (rk_q),
        .rcon    (aes_rcon(rnd_q)),
        .rk_next (rk_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            kvld_q  <= 1'b0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            kvld_q  <= kvld_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        kvld_d  = kvld_q;
        dout_d  = dout_q;
        dvld_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (krdy) begin
                    key_d  = kin;
                    kvld_d = 1'b1;
                end
                // A key arriving with the block is used for that block.
                if (drdy && (kvld_q || krdy)) begin
                    st_d    = din;
                    rk_d    = krdy ? kin : key_q;
                    rnd_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                st_d  = core_dout;
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == NR) begin
                    dout_d  = core_dout;
                    dvld_d  = 1'b1;
                    rnd_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_sel = SEL_FIRST;
        if (state_q == ST_RUN) begin
            if (rnd_q == NR) begin
                core_sel = SEL_LAST;
            end else if (rnd_q != 4'd0) begin
                core_sel = SEL_MID;
            end
        end
    end

    assign core_din = st_q;
    assign core_kin = rk_q;
    assign dout     = dout_q;
    assign dvld     = dvld_q;
    assign busy     = (state_q == ST_RUN);
    assign kvld     = kvld_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a behavioural AES round stands in for the datapath,
// directed FIPS-197 vectors feed a scoreboard that a negedge monitor drains.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] kin, din, dout, core_din, core_kin, core_dout;
    logic         krdy, drdy, dvld, busy, kvld;
    logic [1:0]   core_sel;

    aes_round_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .kin       (kin),
        .krdy      (krdy),
        .din       (din),
        .drdy      (drdy),
        .dout      (dout),
        .dvld      (dvld),
        .busy      (busy),
        .kvld      (kvld),
        .core_din  (core_din),
        .core_kin  (core_kin),
        .core_sel  (core_sel),
        .core_dout (core_dout)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [1:0] sel);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        if (sel == SEL_FIRST) return s ^ k;
        for (int i = 0; i < 16; i++) a[i] = aes_sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) b[4*c+rw] = a[4*((c+rw)%4)+rw];
        if (sel == SEL_MID) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
                a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
            end
        end else begin
            a = b;
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
        return r ^ k;
    endfunction

    always_comb core_dout = aes_round(core_din, core_kin, core_sel);

    typedef struct {
        logic [127:0] ct;
        int           due_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Issue one block; the result is due 12 cycles after the cycle drdy is held.
    task automatic start(input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] c, input logic with_key);
        kin  = k;
        krdy = with_key;
        din  = p;
        drdy = 1'b1;
        sb_q.push_back('{ct: c, due_cyc: cyc + 12});
        tick(1);
        krdy = 1'b0;
        drdy = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (dvld) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dvld actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = sb_q.pop_front();
                $display("result cyc=%0d dout=%h expected=%h", cyc, dout, e.ct);
                check("dout", dout, e.ct);
                check("latency", 128'(cyc), 128'(e.due_cyc));
            end
        end
    end

    initial begin
        RST = 1'b1; kin = '0; din = '0; krdy = 1'b0; drdy = 1'b0;
        tick(3);
        check("rst_dout", dout, '0);
        check("rst_dvld", 128'(dvld), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_kvld", 128'(kvld), 128'(0));
        check("rst_core_din", core_din, '0);
        check("rst_core_kin", core_kin, '0);
        check("rst_core_sel", 128'(core_sel), 128'(SEL_FIRST));
        RST = 1'b0;
        tick(2);

        // drdy with no key loaded is ignored
        din = PT_C1; drdy = 1'b1;
        tick(1);
        drdy = 1'b0;
        check("nokey_busy", 128'(busy), 128'(0));
        check("nokey_kvld", 128'(kvld), 128'(0));
        tick(3);
        check("nokey_busy_later", 128'(busy), 128'(0));

        // key load alone, then drdy the next cycle; watch the round sequence
        kin = K_B; krdy = 1'b1;
        tick(1);
        krdy = 1'b0;
        check("kvld_after_load", 128'(kvld), 128'(1));
        start(K_C1, PT_B, CT_B, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            check("run_busy", 128'(busy), 128'(1));
            check("core_sel", 128'(core_sel),
                  128'((i == 0) ? SEL_FIRST : (i == 10) ? SEL_LAST : SEL_MID));
            if (i == 10) check("rk10", core_kin, RK10_B);
            tick(1);
        end
        check("done_busy", 128'(busy), 128'(0));
        tick(2);

        // same-cycle krdy + drdy picks up the new key
        start(K_C1, PT_C1, CT_C1, 1'b1);
        tick(13);

        // krdy/drdy pulsed mid-run have no effect
        start(K_C1, PT_C1, CT_C1, 1'b0);
        tick(5);
        kin = K_B; krdy = 1'b1; din = PT_B; drdy = 1'b1;
        tick(1);
        krdy = 1'b0; drdy = 1'b0;
        tick(7);
        start(K_B, PT_C1, CT_C1, 1'b0);
        tick(13);

        // drdy held high: one completion every 12 cycles
        kin = K_B; krdy = 1'b0; din = PT_C1; drdy = 1'b1;
        for (int j = 0; j < 3; j++) sb_q.push_back('{ct: CT_C1, due_cyc: cyc + 12 + 12*j});
        tick(25);
        drdy = 1'b0;
        tick(13);

        // reset in the middle of a run
        start(K_B, PT_C1, CT_C1, 1'b0);
        void'(sb_q.pop_back());
        tick(4);
        RST = 1'b1;
        #1;
        check("abort_dout", dout, '0);
        check("abort_dvld", 128'(dvld), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_kvld", 128'(kvld), 128'(0));
        check("abort_core_din", core_din, '0);
        check("abort_core_kin", core_kin, '0);
        check("abort_core_sel", 128'(core_sel), 128'(SEL_FIRST));
        tick(1);
        RST = 1'b0;
        tick(1);
        din = PT_C1; drdy = 1'b1;
        tick(1);
        drdy = 1'b0;
        check("post_abort_busy", 128'(busy), 128'(0));
        check("post_abort_kvld", 128'(kvld), 128'(0));
        tick(14);

        check("pending_results", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption sequencer that drives the combinational round datapath one round per clock. It accepts a 128-bit key and plaintext block and holds the running state and current round key in registers. Each cycle it feeds the round datapath (`core_din`, `core_kin`, `core_sel`), computes the next round key on the fly, and captures the datapath result. It presents the ciphertext with a one-cycle valid pulse after 11 rounds.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous reset, active-high
- `kin`  in  128  cipher key, byte 0 in [127:120]
- `krdy`  in  1  load `kin` (sampled when idle)
- `din`  in  128  plaintext block
- `drdy`  in  1  start encryption of `din` (sampled when idle and key loaded)
- `dout`  out  128  ciphertext, held until the next result
- `dvld`  out  1  one-cycle pulse, `dout` updated this cycle
- `busy`  out  1  encryption in progress
- `kvld`  out  1  a key has been loaded since reset
- `core_din`  out  128  state to round datapath
- `core_kin`  out  128  round key to round datapath
- `core_sel`  out  2  00 initial AddRoundKey, 01 middle round, 10 final round (no MixColumns)
- `core_dout`  in  128  round datapath result, combinational from `core_*`

## Operation
- Registers:
  - `key_r`: stored master key.
  - `st_r`: state.
  - `rk_r`: current round key.
  - `rnd`: 4-bit round counter, 0..10.
  - `busy`, `kvld`, `dout`, `dvld`.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, rnd=0..10).
- IDLE behaviour:
  - `krdy`=1: `key_r`<=`kin`, `kvld`<=1.
  - `drdy`=1 and (`kvld`=1 or `krdy`=1): `st_r`<=`din`, `rk_r`<=(`krdy` ? `kin` : `key_r`), `rnd`<=0, go to RUN.
  - When `krdy` and `drdy` arrive in the same cycle, the block uses the new key.
  - `drdy` with no key ever loaded is ignored.
- RUN, every cycle:
  - `core_din`=`st_r`, `core_kin`=`rk_r`.
  - `core_sel` = 00 when rnd=0, 10 when rnd=10, else 01.
  - At the edge: `st_r`<=`core_dout`, `rk_r`<=KeyExpand(`rk_r`, Rcon[rnd]), `rnd`<=`rnd`+1.
- KeyExpand:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - w0 = [127:96].
  - Rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36. Rcon is only used for rnd 0..9; the expansion result at rnd=10 is don't-care.
- Completing RUN at rnd=10: `dout`<=`core_dout`, `dvld`<=1, `busy`<=0, `rnd`<=0, back to IDLE.
- `krdy`/`drdy` during RUN are ignored: no queueing, no effect on the operation in progress.
- In IDLE, `core_din`=`st_r`, `core_kin`=`rk_r`, `core_sel`=00; their values are don't-care for the consumer.
- RST mid-operation aborts it:
  - all registers go to 0; `kvld`=0, so the key must be reloaded.
  - no `dvld` is produced.

## Timing
- Reset values: `dout`=0, `dvld`=0, `busy`=0, `kvld`=0, `core_din`=0, `core_kin`=0, `core_sel`=00.
- Accept edge T (`drdy` high in IDLE): `busy`=1 from cycle T+1.
- Rounds 0..10 occupy cycles T+1..T+11.
- Cycle T+12: `dvld`=1, `busy`=0, `dout` valid.
- Latency: 12 cycles from `drdy` sample to `dvld`.
- Back-to-back: `drdy` held high in cycle T+12 is accepted at that edge. Throughput is one block per 12 cycles.
- `dvld` is exactly one cycle wide. `dout` is stable until the next completion.
- `krdy` in IDLE: `kvld`=1 from the next cycle. A `drdy` in that next cycle uses the new key.

## Structure
- Shared package `aes_pkg`:
  - `SEL_FIRST`=2'b00, `SEL_MID`=2'b01, `SEL_LAST`=2'b10.
  - `NR`=10.
  - Rcon table function.
  - S-box function `aes_sbox(byte)`, shared with the SubBytes stage.
- Sub-module `aes_key_expand_step` (in: rk[127:0], rcon[7:0]; out: rk_next[127:0]). Purely combinational; contains four S-box instances.
- The sequencer does not instantiate the round datapath. Integration wires `core_*` at the top level.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, `drdy` with pt 00112233445566778899aabbccddeeff. Required: `dvld` exactly 12 cycles after `drdy`, `dout`=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key schedule: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734. Required: `core_kin` at rnd=10 is d014f9a8c9ee2589e13f0cc8b6630ca6, `dout`=3925841d02dc09fbdc118597196a0b32, `core_sel` sequence 00, 01×9, 10.
- Same-cycle `krdy`+`drdy` with the C.1 key after the 2b7e key was loaded. Required: C.1 ciphertext.
- `drdy` and `krdy` pulsed at rnd=5 of a C.1 run. Required: no effect; C.1 result at T+12, `key_r` unchanged.
- `drdy` held high continuously. Required: `dvld` every 12 cycles, each `dout` correct.
- `drdy` before any key load: no `busy`. RST asserted at rnd=4: all outputs 0 immediately, no `dvld`, `kvld`=0.
